// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALU_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// Maps an R-type funct field to the ALU operation; unknown functs add.
module mips_aludec
    import mips_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALU_W-1:0]   alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: Moore control vector per state, async reset to FETCH.
module mips_controller
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               pcwrite,
    output logic               pcwriteCond,
    output logic [1:0]         pcsource,
    output logic               memtoreg,
    output logic               regdst,
    output logic               iord,
    output logic               regwrite,
    output logic               irwrite,
    output logic               memwrite,
    output logic [ALU_W-1:0]   alucontrol,
    output logic [STATE_W-1:0] state
);

    state_t             state_q;
    state_t             state_d;
    logic [ALU_W-1:0]   rtype_alu;

    // zero is qualified by pcwriteCond inside the datapath
    logic unused_zero;
    assign unused_zero = zero;

    mips_aludec u_aludec (
        .funct      (funct),
        .alucontrol (rtype_alu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = STATE_W'(state_q);

    // Next-state and Moore output decode; encodings 12-15 fall to defaults and FETCH
    always_comb begin
        state_d     = S_FETCH;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcwrite     = 1'b0;
        pcwriteCond = 1'b0;
        pcsource    = 2'b00;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        iord        = 1'b0;
        regwrite    = 1'b0;
        irwrite     = 1'b0;
        memwrite    = 1'b0;
        alucontrol  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = rtype_alu;
                state_d    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca     = 1'b1;
                alucontrol  = ALU_SUB;
                pcsource    = 2'b01;
                pcwriteCond = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule
